// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory responder.
package mem_pkg;

    // Access size encoding as driven by the core; 2'b11 is not a legal size.
    typedef enum logic [1:0] {
        MEM_B = 2'b00,
        MEM_H = 2'b01,
        MEM_W = 2'b10
    } mem_size_t;

    // Responder FSM states.
    typedef enum logic [1:0] {
        MS_IDLE = 2'b00,
        MS_WAIT = 2'b01,
        MS_RESP = 2'b10
    } mem_state_t;

    // Byte-lane enables within a 32-bit word.
    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_B0   = 4'b0001;
    localparam logic [3:0] BE_B1   = 4'b0010;
    localparam logic [3:0] BE_B2   = 4'b0100;
    localparam logic [3:0] BE_B3   = 4'b1000;
    localparam logic [3:0] BE_H0   = 4'b0011;
    localparam logic [3:0] BE_H1   = 4'b1100;
    localparam logic [3:0] BE_W    = 4'b1111;

    // True when the low address bits do not suit the access size (illegal size counts as bad).
    function automatic logic mem_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            MEM_B:   bad = 1'b0;
            MEM_H:   bad = addr_lo[0];
            MEM_W:   bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: load extraction/extension and store byte enables.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] rdata_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_rep
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Load side: pick the addressed lane and extend it to 32 bits.
    always_comb begin
        byte_s    = 8'h00;
        half_s    = 16'h0000;
        load_data = 32'h0000_0000;
        case (size)
            MEM_B: begin
                case (addr_lo)
                    2'b00:   byte_s = rdata_word[7:0];
                    2'b01:   byte_s = rdata_word[15:8];
                    2'b10:   byte_s = rdata_word[23:16];
                    2'b11:   byte_s = rdata_word[31:24];
                    default: byte_s = 8'h00;
                endcase
                load_data = {{24{sign_ext & byte_s[7]}}, byte_s};
            end
            MEM_H: begin
                if (addr_lo[1]) begin
                    half_s = rdata_word[31:16];
                end else begin
                    half_s = rdata_word[15:0];
                end
                load_data = {{16{sign_ext & half_s[15]}}, half_s};
            end
            MEM_W:   load_data = rdata_word;
            default: load_data = 32'h0000_0000;
        endcase
    end

    // Store side: byte enables from size/offset and data replicated onto every lane.
    always_comb begin
        byte_en   = BE_NONE;
        wdata_rep = wdata;
        case (size)
            MEM_B: begin
                wdata_rep = {4{wdata[7:0]}};
                case (addr_lo)
                    2'b00:   byte_en = BE_B0;
                    2'b01:   byte_en = BE_B1;
                    2'b10:   byte_en = BE_B2;
                    2'b11:   byte_en = BE_B3;
                    default: byte_en = BE_NONE;
                endcase
            end
            MEM_H: begin
                wdata_rep = {2{wdata[15:0]}};
                if (addr_lo[1]) begin
                    byte_en = BE_H1;
                end else begin
                    byte_en = BE_H0;
                end
            end
            MEM_W: begin
                wdata_rep = wdata;
                byte_en   = BE_W;
            end
            default: begin
                wdata_rep = wdata;
                byte_en   = BE_NONE;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM behind a fixed-latency busy/ack handshake.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] memload,
    output logic        busy,
    output logic        ack,
    output logic        err
);

    localparam int         IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    logic [31:0]      ram_r [0:DEPTH_WORDS-1];

    mem_state_t       state_r, next_state_s;
    logic [3:0]       cnt_r, cnt_dec_s;
    logic [IDX_W-1:0] idx_r;
    logic [1:0]       addr_lo_r, size_r;
    logic [31:0]      wdata_r, memload_r;
    logic             sign_ext_r, is_write_r;
    logic             busy_r, ack_r, err_r;

    logic             illegal_s, accept_s, reject_s, load_upd_s;
    logic             in_idle_s;
    logic [IDX_W-1:0] sel_idx_s;
    logic [1:0]       sel_lo_s, sel_size_s;
    logic [31:0]      sel_wdata_s, rdata_s, load_data_s, wdata_rep_s;
    logic             sel_sext_s, sel_write_s;
    logic [3:0]       byte_en_s;

    // Request qualification: exactly one direction, legal size, aligned, in range.
    always_comb begin
        in_idle_s = (state_r == MS_IDLE);
        illegal_s = (memRead & memWrite)
                  | (size == 2'b11)
                  | mem_misaligned(size, addr[1:0])
                  | (addr[31:2] >= 30'(DEPTH_WORDS));
        accept_s  = in_idle_s & (memRead ^ memWrite) & ~illegal_s;
        reject_s  = in_idle_s & (memRead | memWrite) & illegal_s;
        cnt_dec_s = cnt_r - 4'd1;
    end

    // Live inputs steer the datapath in IDLE (a LATENCY=1 read loads on the accept edge); captured values otherwise.
    always_comb begin
        if (in_idle_s) begin
            sel_idx_s   = addr[IDX_W+1:2];
            sel_lo_s    = addr[1:0];
            sel_size_s  = size;
            sel_sext_s  = sign_ext;
            sel_wdata_s = wdata;
            sel_write_s = memWrite;
        end else begin
            sel_idx_s   = idx_r;
            sel_lo_s    = addr_lo_r;
            sel_size_s  = size_r;
            sel_sext_s  = sign_ext_r;
            sel_wdata_s = wdata_r;
            sel_write_s = is_write_r;
        end
        rdata_s = ram_r[sel_idx_s];
    end

    mem_lane_align u_align (
        .addr_lo    (sel_lo_s),
        .size       (sel_size_s),
        .sign_ext   (sel_sext_s),
        .rdata_word (rdata_s),
        .wdata      (sel_wdata_s),
        .load_data  (load_data_s),
        .byte_en    (byte_en_s),
        .wdata_rep  (wdata_rep_s)
    );

    // Next-state logic; the counter reaching zero on this edge moves WAIT into RESP.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            MS_IDLE: begin
                if (accept_s) begin
                    next_state_s = (LATENCY == 1) ? MS_RESP : MS_WAIT;
                end else begin
                    next_state_s = MS_IDLE;
                end
            end
            MS_WAIT: begin
                if (cnt_dec_s == 4'd0) begin
                    next_state_s = MS_RESP;
                end else begin
                    next_state_s = MS_WAIT;
                end
            end
            MS_RESP: next_state_s = MS_IDLE;
            default: next_state_s = MS_IDLE;
        endcase
        load_upd_s = (next_state_s == MS_RESP) && (state_r != MS_RESP) && !sel_write_s;
    end

    // FSM, latency counter, request capture and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= MS_IDLE;
            cnt_r      <= 4'd0;
            idx_r      <= '0;
            addr_lo_r  <= 2'b00;
            size_r     <= 2'b00;
            wdata_r    <= 32'h0000_0000;
            sign_ext_r <= 1'b0;
            is_write_r <= 1'b0;
            memload_r  <= 32'h0000_0000;
            busy_r     <= 1'b0;
            ack_r      <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s != MS_IDLE);
            ack_r   <= (next_state_s == MS_RESP);
            err_r   <= reject_s;
            if (accept_s) begin
                idx_r      <= addr[IDX_W+1:2];
                addr_lo_r  <= addr[1:0];
                size_r     <= size;
                wdata_r    <= wdata;
                sign_ext_r <= sign_ext;
                is_write_r <= memWrite;
                cnt_r      <= LAT_M1;
            end else if (state_r == MS_WAIT) begin
                cnt_r <= cnt_dec_s;
            end
            if (load_upd_s) begin
                memload_r <= load_data_s;
            end
        end
    end

    // Store commit on the edge leaving RESP; the RAM has no reset so contents survive it.
    always_ff @(posedge clk) begin
        if ((state_r == MS_RESP) && is_write_r) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en_s[b]) begin
                    ram_r[idx_r][8*b +: 8] <= wdata_rep_s[8*b +: 8];
                end
            end
        end
    end

    assign memload = memload_r;
    assign busy    = busy_r;
    assign ack     = ack_r;
    assign err     = err_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder at LATENCY 2, 1 and 15.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        memRead, memWrite, sign_ext;
    logic [31:0] addr, wdata;
    logic [1:0]  size;

    logic [31:0] ml_a, ml_b, ml_c, ml_m;
    logic        busy_a, busy_b, busy_c, busy_m;
    logic        ack_a, ack_b, ack_c, ack_m;
    logic        err_a, err_b, err_c, err_m;

    int sel;
    int vec_cnt  = 0;
    int miss_cnt = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [1:0]  sz;
        string       name;
    } ill_t;
    ill_t ill_tab [6];

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_dut_l2 (
        .clk(clk), .rst(rst), .memRead(memRead), .memWrite(memWrite), .addr(addr),
        .wdata(wdata), .size(size), .sign_ext(sign_ext),
        .memload(ml_a), .busy(busy_a), .ack(ack_a), .err(err_a));

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst(rst), .memRead(memRead), .memWrite(memWrite), .addr(addr),
        .wdata(wdata), .size(size), .sign_ext(sign_ext),
        .memload(ml_b), .busy(busy_b), .ack(ack_b), .err(err_b));

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(15)) u_dut_l15 (
        .clk(clk), .rst(rst), .memRead(memRead), .memWrite(memWrite), .addr(addr),
        .wdata(wdata), .size(size), .sign_ext(sign_ext),
        .memload(ml_c), .busy(busy_c), .ack(ack_c), .err(err_c));

    // Route the outputs of the instance under test to one set of observation signals.
    always_comb begin
        case (sel)
            1: begin ml_m = ml_b; busy_m = busy_b; ack_m = ack_b; err_m = err_b; end
            2: begin ml_m = ml_c; busy_m = busy_c; ack_m = ack_c; err_m = err_c; end
            default: begin ml_m = ml_a; busy_m = busy_a; ack_m = ack_a; err_m = err_a; end
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [1:0] sz, input logic sx);
        memRead  = rd;
        memWrite = wr;
        addr     = a;
        wdata    = wd;
        size     = sz;
        sign_ext = sx;
    endtask

    // One request: accept edge, then wait (bounded) for ack; reports latency, busy cycles and memload at ack.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [1:0] sz, input logic sx,
                          input bit scribble, output int cyc, output int busy_n,
                          output logic [31:0] ml);
        drive(rd, wr, a, wd, sz, sx);
        step();
        memRead  = 1'b0;
        memWrite = 1'b0;
        cyc      = 1;
        busy_n   = 0;
        while (ack_m !== 1'b1 && cyc < 40) begin
            if (busy_m === 1'b1) busy_n++;
            if (scribble) begin
                addr  = $urandom;
                wdata = $urandom;
                size  = 2'($urandom_range(3, 0));
            end
            step();
            cyc++;
        end
        if (busy_m === 1'b1) busy_n++;
        ml = ml_m;
        step();
        if (busy_m === 1'b1) busy_n++;
    endtask

    task automatic test_reset();
        sel = 0;
        vec_cnt++; if (ml_a !== 32'h0) begin miss_cnt++; $display("FAIL reset_memload: got %h expected %h", ml_a, 32'h0); end
        vec_cnt++; if (busy_a !== 1'b0) begin miss_cnt++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
        vec_cnt++; if (ack_a !== 1'b0 || ack_b !== 1'b0 || ack_c !== 1'b0) begin miss_cnt++; $display("FAIL reset_ack: got %b%b%b expected 000", ack_a, ack_b, ack_c); end
        vec_cnt++; if (err_a !== 1'b0) begin miss_cnt++; $display("FAIL reset_err: got %b expected 0", err_a); end
    endtask

    task automatic test_sw_lw();
        int cyc, bn;
        logic [31:0] ml;
        sel = 0;
        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 1'b0, cyc, bn, ml);
        vec_cnt++; if (cyc !== 2) begin miss_cnt++; $display("FAIL sw_latency: got %0d expected 2", cyc); end
        vec_cnt++; if (bn !== 2) begin miss_cnt++; $display("FAIL sw_busy_cycles: got %0d expected 2", bn); end
        vec_cnt++; if (ml !== 32'h0) begin miss_cnt++; $display("FAIL sw_memload_held: got %h expected %h", ml, 32'h0); end
        access(1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 1'b0, cyc, bn, ml);
        vec_cnt++; if (cyc !== 2) begin miss_cnt++; $display("FAIL lw_latency: got %0d expected 2", cyc); end
        vec_cnt++; if (bn !== 2) begin miss_cnt++; $display("FAIL lw_busy_cycles: got %0d expected 2", bn); end
        vec_cnt++; if (ml !== 32'hDEADBEEF) begin miss_cnt++; $display("FAIL lw_data: got %h expected %h", ml, 32'hDEADBEEF); end
        access(1'b0, 1'b1, 32'h40, 32'hA5A55A5A, 2'b10, 1'b0, 1'b0, cyc, bn, ml);
        access(1'b1, 1'b0, 32'h40, 32'h0, 2'b10, 1'b0, 1'b0, cyc, bn, ml);
        vec_cnt++; if (ml !== 32'hA5A55A5A) begin miss_cnt++; $display("FAIL raw_back_to_back: got %h expected %h", ml, 32'hA5A55A5A); end
    endtask

    task automatic test_reset_mid_write();
        int cyc, bn, acks;
        logic [31:0] ml;
        sel = 0;
        drive(1'b0, 1'b1, 32'h10, 32'h12345678, 2'b10, 1'b0);
        step();
        memWrite = 1'b0;
        vec_cnt++; if (busy_m !== 1'b1) begin miss_cnt++; $display("FAIL abort_busy_before: got %b expected 1", busy_m); end
        rst = 1'b1;
        #1;
        vec_cnt++; if (busy_m !== 1'b0) begin miss_cnt++; $display("FAIL abort_busy_on_rst: got %b expected 0", busy_m); end
        step();
        rst  = 1'b0;
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            if (ack_m === 1'b1) acks++;
            step();
        end
        vec_cnt++; if (acks !== 0) begin miss_cnt++; $display("FAIL abort_no_ack: got %0d acks expected 0", acks); end
        access(1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 1'b0, cyc, bn, ml);
        vec_cnt++; if (ml !== 32'hDEADBEEF) begin miss_cnt++; $display("FAIL abort_old_word: got %h expected %h", ml, 32'hDEADBEEF); end
    endtask

    task automatic test_byte_half();
        int cyc, bn;
        logic [31:0] ml;
        sel = 0;
        access(1'b0, 1'b1, 32'h20, 32'h11223344, 2'b10, 1'b0, 1'b0, cyc, bn, ml);
        access(1'b0, 1'b1, 32'h21, 32'hFFFFFFAA, 2'b00, 1'b0, 1'b0, cyc, bn, ml);
        access(1'b0, 1'b1, 32'h22, 32'h77778001, 2'b01, 1'b0, 1'b0, cyc, bn, ml);
        access(1'b1, 1'b0, 32'h20, 32'h0, 2'b10, 1'b1, 1'b0, cyc, bn, ml);
        vec_cnt++; if (ml !== 32'h8001AA44) begin miss_cnt++; $display("FAIL merged_word: got %h expected %h", ml, 32'h8001AA44); end
        access(1'b1, 1'b0, 32'h21, 32'h0, 2'b00, 1'b1, 1'b0, cyc, bn, ml);
        vec_cnt++; if (ml !== 32'hFFFFFFAA) begin miss_cnt++; $display("FAIL lb: got %h expected %h", ml, 32'hFFFFFFAA); end
        access(1'b1, 1'b0, 32'h21, 32'h0, 2'b00, 1'b0, 1'b0, cyc, bn, ml);
        vec_cnt++; if (ml !== 32'h000000AA) begin miss_cnt++; $display("FAIL lbu: got %h expected %h", ml, 32'h000000AA); end
        access(1'b1, 1'b0, 32'h22, 32'h0, 2'b01, 1'b1, 1'b0, cyc, bn, ml);
        vec_cnt++; if (ml !== 32'hFFFF8001) begin miss_cnt++; $display("FAIL lh: got %h expected %h", ml, 32'hFFFF8001); end
        access(1'b1, 1'b0, 32'h22, 32'h0, 2'b01, 1'b0, 1'b0, cyc, bn, ml);
        vec_cnt++; if (ml !== 32'h00008001) begin miss_cnt++; $display("FAIL lhu: got %h expected %h", ml, 32'h00008001); end
    endtask

    task automatic test_illegal();
        int cyc, bn, acks;
        logic [31:0] ml, ml_before;
        sel = 0;
        ill_tab[0] = '{rd: 1'b1, wr: 1'b0, a: 32'h22,  sz: 2'b10, name: "lw_misaligned"};
        ill_tab[1] = '{rd: 1'b1, wr: 1'b0, a: 32'h23,  sz: 2'b01, name: "lh_misaligned"};
        ill_tab[2] = '{rd: 1'b1, wr: 1'b1, a: 32'h20,  sz: 2'b10, name: "both_dirs"};
        ill_tab[3] = '{rd: 1'b0, wr: 1'b1, a: 32'h20,  sz: 2'b11, name: "size11"};
        ill_tab[4] = '{rd: 1'b1, wr: 1'b0, a: 32'h400, sz: 2'b10, name: "oob_read"};
        ill_tab[5] = '{rd: 1'b0, wr: 1'b1, a: 32'h420, sz: 2'b10, name: "oob_write"};
        ml_before = 32'h00008001;
        for (int i = 0; i < 6; i++) begin
            drive(ill_tab[i].rd, ill_tab[i].wr, ill_tab[i].a, 32'h0, ill_tab[i].sz, 1'b0);
            step();
            memRead  = 1'b0;
            memWrite = 1'b0;
            vec_cnt++; if (err_m !== 1'b1 || busy_m !== 1'b0) begin miss_cnt++; $display("FAIL %s_err_pulse: got err=%b busy=%b expected err=1 busy=0", ill_tab[i].name, err_m, busy_m); end
            acks = (ack_m === 1'b1) ? 1 : 0;
            step();
            vec_cnt++; if (err_m !== 1'b0) begin miss_cnt++; $display("FAIL %s_err_width: got %b expected 0", ill_tab[i].name, err_m); end
            for (int j = 0; j < 4; j++) begin
                if (ack_m === 1'b1) acks++;
                step();
            end
            vec_cnt++; if (acks !== 0) begin miss_cnt++; $display("FAIL %s_no_ack: got %0d acks expected 0", ill_tab[i].name, acks); end
            vec_cnt++; if (ml_m !== ml_before) begin miss_cnt++; $display("FAIL %s_memload: got %h expected %h", ill_tab[i].name, ml_m, ml_before); end
        end
        access(1'b1, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 1'b0, cyc, bn, ml);
        vec_cnt++; if (ml !== 32'h8001AA44) begin miss_cnt++; $display("FAIL illegal_ram_intact: got %h expected %h", ml, 32'h8001AA44); end
    endtask

    task automatic test_latency_sweep();
        int cyc, bn;
        logic [31:0] ml;
        repeat (20) step();
        sel = 1;
        access(1'b0, 1'b1, 32'h30, 32'hCAFEF00D, 2'b10, 1'b0, 1'b0, cyc, bn, ml);
        vec_cnt++; if (cyc !== 1) begin miss_cnt++; $display("FAIL lat1_sw_latency: got %0d expected 1", cyc); end
        access(1'b1, 1'b0, 32'h30, 32'h0, 2'b10, 1'b0, 1'b0, cyc, bn, ml);
        vec_cnt++; if (cyc !== 1) begin miss_cnt++; $display("FAIL lat1_lw_latency: got %0d expected 1", cyc); end
        vec_cnt++; if (bn !== 1) begin miss_cnt++; $display("FAIL lat1_busy_cycles: got %0d expected 1", bn); end
        vec_cnt++; if (ml !== 32'hCAFEF00D) begin miss_cnt++; $display("FAIL lat1_lw_data: got %h expected %h", ml, 32'hCAFEF00D); end
        repeat (20) step();
        sel = 2;
        access(1'b0, 1'b1, 32'h34, 32'h0BADF00D, 2'b10, 1'b0, 1'b1, cyc, bn, ml);
        vec_cnt++; if (cyc !== 15) begin miss_cnt++; $display("FAIL lat15_sw_latency: got %0d expected 15", cyc); end
        vec_cnt++; if (bn !== 15) begin miss_cnt++; $display("FAIL lat15_busy_cycles: got %0d expected 15", bn); end
        access(1'b1, 1'b0, 32'h34, 32'h0, 2'b10, 1'b0, 1'b1, cyc, bn, ml);
        vec_cnt++; if (cyc !== 15) begin miss_cnt++; $display("FAIL lat15_lw_latency: got %0d expected 15", cyc); end
        vec_cnt++; if (ml !== 32'h0BADF00D) begin miss_cnt++; $display("FAIL lat15_lw_data: got %h expected %h", ml, 32'h0BADF00D); end
    endtask

    task automatic test_held_request();
        int cyc;
        repeat (20) step();
        sel = 0;
        drive(1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
        step();
        cyc = 1;
        while (ack_m !== 1'b1 && cyc < 40) begin step(); cyc++; end
        vec_cnt++; if (cyc !== 2) begin miss_cnt++; $display("FAIL held_first_latency: got %0d expected 2", cyc); end
        vec_cnt++; if (ml_m !== 32'hDEADBEEF) begin miss_cnt++; $display("FAIL held_first_data: got %h expected %h", ml_m, 32'hDEADBEEF); end
        step();
        vec_cnt++; if (busy_m !== 1'b0) begin miss_cnt++; $display("FAIL held_idle_gap: got busy=%b expected 0", busy_m); end
        addr = 32'h20;
        step();
        memRead = 1'b0;
        cyc = 1;
        while (ack_m !== 1'b1 && cyc < 40) begin step(); cyc++; end
        vec_cnt++; if (cyc !== 2) begin miss_cnt++; $display("FAIL held_second_latency: got %0d expected 2", cyc); end
        vec_cnt++; if (ml_m !== 32'h8001AA44) begin miss_cnt++; $display("FAIL held_second_data: got %h expected %h", ml_m, 32'h8001AA44); end
        step();
    endtask

    // Test sequence.
    initial begin
        sel = 0;
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        step();
        test_sw_lw();
        test_reset_mid_write();
        test_byte_half();
        test_illegal();
        test_latency_sweep();
        test_held_request();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory responder that services the load/store side of the single-cycle core (memRead/memWrite, address, store data).
- Returns memload after a fixed, parameterised latency using an internal word-organised RAM.
- Replaces the bench-driven memload so that lw/lh/lb/sw/sh/sb can be run end-to-end.
- Has a busy/ack handshake, so the core can later be stalled on multi-cycle memory.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the RAM; word index = addr[31:2].
- LATENCY, 2, cycles from request accept to ack; legal range 1..15.

Ports:
- clk  in  1  clock; one clock, rising edge.
- rst  in  1  reset; asynchronous and active-high.
- memRead  in  1  load request.
- memWrite  in  1  store request.
- addr  in  32  byte address (core aluOut).
- wdata  in  32  store data (core regData2); low bytes used for sb/sh.
- size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- sign_ext  in  1  1 = sign-extend byte/half loads (LB/LH); 0 = zero-extend (LBU/LHU).
- memload  out  32  load result.
- busy  out  1  access in progress.
- ack  out  1  one-cycle pulse, access complete.
- err  out  1  one-cycle pulse, request rejected.

Behaviour:
- Reset (async, rst=1): state IDLE, counter 0, memload 0, busy 0, ack 0, err 0. RAM contents are not cleared and are preserved across reset.
- Reset during WAIT aborts the access. A pending store is never committed. No ack is issued.
- States: IDLE, WAIT, RESP.
  - IDLE: a request is valid when exactly one of memRead/memWrite is high at a rising edge.
    - Valid and legal: capture addr, wdata, size, sign_ext and direction; load counter with LATENCY-1; go to WAIT, or straight to RESP if LATENCY=1.
  - Illegal request, detected in IDLE: err pulses for one cycle, there is no access, and the state stays IDLE. Illegal means any of:
    - both memRead and memWrite high;
    - size=11;
    - misaligned (half with addr[0]=1, word with addr[1:0]!=0);
    - word index >= DEPTH_WORDS.
  - WAIT: counter decrements each cycle; at 0, go to RESP. Inputs are ignored while in WAIT (captured values are used).
  - RESP: ack=1 for this cycle only; next state IDLE.
    - Read: memload updates at the edge entering RESP and is held until the next read ack.
    - Write: byte lanes are written at the edge leaving RESP.
- busy=1 in WAIT and RESP, 0 in IDLE and during err.
- Timing: ack is asserted exactly LATENCY cycles after the accepting edge.
- The core must drop its request in the ack cycle. A request still high in the cycle after ack is a new request.
- Load alignment:
  - byte lane = addr[1:0];
  - half lane = addr[1];
  - extended to 32 bits per sign_ext; word loads ignore sign_ext.
- Store merge: only the addressed lanes change (byte enables from size/addr[1:0]). Other bytes of the word keep their old value.
- Read-after-write to the same word on back-to-back requests returns the new data (the write commits before the next accept can read).
- memload is unchanged by writes, errors and reset-abort.

Decomposition:
- Shared package mem_pkg:
  - size enum (MEM_B, MEM_H, MEM_W);
  - state enum (MS_IDLE, MS_WAIT, MS_RESP);
  - lane byte-enable constants.
- One sub-module, mem_lane_align, kept combinational:
  - load side: extract and extend the addressed lane;
  - store side: generate the 4-bit byte enable and the replicated write data.
- The FSM, counter and RAM stay in data_mem_responder.

Test Plan:
- Reset mid-write: store request, rst pulsed in WAIT, then a read of the same word → no ack, old word returned; busy=0 immediately on rst.
- sw then lw, LATENCY=2: sw addr=0x10 wdata=0xDEADBEEF, then lw addr=0x10 → ack 2 cycles after each accept; memload=0xDEADBEEF; busy high exactly 2 cycles per access.
- Byte/half stores and loads: from word 0x11223344 at 0x20, do sb 0xAA @0x21 then sh 0x8001 @0x22 → word=0x8001AA44.
  - lb @0x21 → 0xFFFFFFAA; lbu @0x21 → 0x000000AA.
  - lh @0x22 → 0xFFFF8001; lhu @0x22 → 0x00008001.
- Illegal requests → one err pulse each, no ack, memload unchanged, RAM unchanged:
  - lw @0x22 (misaligned);
  - lh @0x23 (misaligned);
  - both memRead and memWrite high;
  - size=11;
  - addr=0x400 with DEPTH_WORDS=256.
- LATENCY sweep 1 and 15: ack at exactly 1 and 15 cycles. Changing addr/wdata during WAIT has no effect on the result.
- Held request: memRead left high for 1 cycle after ack → second access accepted in the following IDLE cycle, second ack LATENCY cycles later.
